// File: rtl/dbus_ram_responder_if.sv
// Request/response bundle between a data-bus requester (CPU memory stage)
// and the RAM responder; req_* flows toward memory, resp_* back to the core.
interface dbus_ram_responder_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [3:0]  req_strobe;
  logic [31:0] req_data;
  logic        resp_addr_ok;
  logic        resp_data_ok;
  logic [31:0] resp_data;

  modport master (
    output req_valid, req_addr, req_size, req_strobe, req_data,
    input  resp_addr_ok, resp_data_ok, resp_data
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_strobe, req_data,
    output resp_addr_ok, resp_data_ok, resp_data
  );
endinterface

// File: rtl/dbus_ram_responder.sv
// Word-addressed RAM behind the addr_ok/data_ok handshake: one transaction at a
// time, byte-strobed writes, read data returned after a fixed or LFSR-drawn wait.
module dbus_ram_responder #(
  parameter int ADDR_BITS    = 10,
  parameter int LATENCY      = 2,
  parameter bit RANDOM_DELAY = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  dbus_ram_responder_if.slave dbus
);
  localparam int         DEPTH = 2 ** ADDR_BITS;
  localparam logic [3:0] LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                 state, state_nx;
  logic [31:0]            mem [DEPTH];
  logic [31:0]            rdata_q;
  logic [31:0]            hold_q;
  logic [3:0]             cnt, cnt_nx;
  logic [15:0]            lfsr;
  logic                   accept;
  logic                   addr_ok;
  logic                   data_ok;
  logic [ADDR_BITS-1:0]   idx;
  logic [3:0]             wait_ld;
  logic                   unused_ok;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    // Fibonacci taps 16,14,13,11 shifted in at the LSB
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strobe);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (strobe[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  assign idx     = dbus.req_addr[ADDR_BITS+1:2];
  assign wait_ld = RANDOM_DELAY ? lfsr[3:0] : LAT;
  // size, byte offset and the aliased upper address bits carry no meaning here
  assign unused_ok = ^{dbus.req_size, dbus.req_addr[31:ADDR_BITS+2], dbus.req_addr[1:0]};

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    addr_ok  = 1'b0;
    data_ok  = 1'b0;
    case (state)
      IDLE: begin
        addr_ok = dbus.req_valid && !reset;
        if (addr_ok) begin
          accept   = 1'b1;
          cnt_nx   = wait_ld;
          state_nx = (wait_ld != 4'd0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt <= 4'd1) state_nx = RESP;
      end
      RESP: begin
        data_ok  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      lfsr    <= 16'hACE1;
      rdata_q <= 32'd0;
      hold_q  <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      lfsr  <= lfsr_step(lfsr);
      if (accept)        rdata_q <= mem[idx];
      if (state == RESP) hold_q  <= rdata_q;
    end
  end

  // RAM has no reset; the read above sees the pre-write word on the same edge
  always_ff @(posedge clk) begin
    if (accept && (dbus.req_strobe != 4'b0000))
      mem[idx] <= merge_bytes(mem[idx], dbus.req_data, dbus.req_strobe);
  end

  assign dbus.resp_addr_ok = addr_ok;
  assign dbus.resp_data_ok = data_ok;
  assign dbus.resp_data    = (state == RESP) ? rdata_q : hold_q;
endmodule
